// File: rtl/lc3_bus_keeper.sv
// One-hot merge of N gated sources onto the LC-3 datapath bus with a bus keeper,
// lowest-index priority on collisions, and sticky/counted contention diagnostics.
module lc3_bus_keeper #(
   parameter int WIDTH   = 16,
   parameter int SOURCES = 4,
   parameter int CNT_W   = 8,
   parameter bit KEEP    = 1'b1,
   localparam int IDX_W  = $clog2(SOURCES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SOURCES-1:0]         gate,
   input  logic [SOURCES*WIDTH-1:0]   data_in,
   input  logic                       clear_err,
   output logic [WIDTH-1:0]           bus,
   output logic                       driven,
   output logic                       contention,
   output logic [IDX_W-1:0]           last_src,
   output logic                       err_sticky,
   output logic [CNT_W-1:0]           contention_count
);

   // There is no handshake: a source owns the bus for exactly the cycles its
   // gate bit is high, and consumers sample bus only on the rising clk edge.

   logic [WIDTH-1:0] held;
   logic [WIDTH-1:0] win_data;
   logic [IDX_W-1:0] win_idx;
   logic             found;

   assign driven     = |gate;
   // More than one bit set iff clearing the lowest set bit leaves something.
   assign contention = |(gate & (gate - SOURCES'(1)));

   always_comb begin
      win_idx  = '0;
      win_data = '0;
      found    = 1'b0;
      for (int i = 0; i < SOURCES; i++) begin
         if (gate[i] && !found) begin
            found    = 1'b1;
            win_idx  = IDX_W'(i);
            win_data = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      if (driven)
         bus = win_data;
      else if (KEEP)
         bus = held;
      else
         bus = '0;
   end

   // The held value tracks the winner even with KEEP=0, so switching policy
   // never exposes a stale value.
   always_ff @(posedge clk) begin
      if (reset) begin
         held     <= '0;
         last_src <= '0;
      end else if (driven) begin
         held     <= win_data;
         last_src <= win_idx;
      end
   end

   // A collision on the same edge as clear_err is kept: the new event wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky       <= 1'b0;
         contention_count <= '0;
      end else if (clear_err && contention) begin
         err_sticky       <= 1'b1;
         contention_count <= CNT_W'(1);
      end else if (clear_err) begin
         err_sticky       <= 1'b0;
         contention_count <= '0;
      end else if (contention) begin
         err_sticky <= 1'b1;
         if (contention_count != {CNT_W{1'b1}})
            contention_count <= contention_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_lc3_bus_keeper.sv
// Directed bench for lc3_bus_keeper: default, KEEP=0 and CNT_W=2 instances share stimulus.
module tb_lc3_bus_keeper;

   localparam int W = 16;
   localparam int S = 4;

   logic           clk;
   logic           reset;
   logic [S-1:0]   gate;
   logic [S*W-1:0] data_in;
   logic           clear_err;

   logic [W-1:0] bus_a, bus_k, bus_c;
   logic         driven_a, driven_k, driven_c;
   logic         cont_a, cont_k, cont_c;
   logic [1:0]   src_a, src_k, src_c;
   logic         err_a, err_k, err_c;
   logic [7:0]   cnt_a, cnt_k;
   logic [1:0]   cnt_c;

   int n_cmp = 0;
   int n_bad = 0;

   lc3_bus_keeper #(.WIDTH(W), .SOURCES(S), .CNT_W(8), .KEEP(1'b1)) dut (
      .clk(clk), .reset(reset), .gate(gate), .data_in(data_in), .clear_err(clear_err),
      .bus(bus_a), .driven(driven_a), .contention(cont_a), .last_src(src_a),
      .err_sticky(err_a), .contention_count(cnt_a)
   );

   lc3_bus_keeper #(.WIDTH(W), .SOURCES(S), .CNT_W(8), .KEEP(1'b0)) dut_k0 (
      .clk(clk), .reset(reset), .gate(gate), .data_in(data_in), .clear_err(clear_err),
      .bus(bus_k), .driven(driven_k), .contention(cont_k), .last_src(src_k),
      .err_sticky(err_k), .contention_count(cnt_k)
   );

   lc3_bus_keeper #(.WIDTH(W), .SOURCES(S), .CNT_W(2), .KEEP(1'b1)) dut_c2 (
      .clk(clk), .reset(reset), .gate(gate), .data_in(data_in), .clear_err(clear_err),
      .bus(bus_c), .driven(driven_c), .contention(cont_c), .last_src(src_c),
      .err_sticky(err_c), .contention_count(cnt_c)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [S-1:0] g, input logic clr);
      gate      = g;
      clear_err = clr;
      #1;
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      reset     = 1'b1;
      gate      = '0;
      clear_err = 1'b0;
      data_in   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      tick();
      tick();
      reset = 1'b0;
      #1;

      // reset state
      check("rst_bus",     bus_a,    32'h0);
      check("rst_bus_k0",  bus_k,    32'h0);
      check("rst_src",     src_a,    32'h0);
      check("rst_err",     err_a,    32'h0);
      check("rst_cnt",     cnt_a,    32'h0);
      check("rst_driven",  driven_a, 32'h0);
      check("rst_cont",    cont_a,   32'h0);

      // single drive then keep
      drive(4'b0100, 1'b0);
      check("drv_bus",     bus_a,    32'hCCCC);
      check("drv_bus_k0",  bus_k,    32'hCCCC);
      check("drv_driven",  driven_a, 32'h1);
      check("drv_cont",    cont_a,   32'h0);
      tick();
      check("drv_src",     src_a,    32'h2);
      drive(4'b0000, 1'b0);
      check("keep_bus0",   bus_a,    32'hCCCC);
      check("keep_k0_0",   bus_k,    32'h0);
      check("idle_driven", driven_a, 32'h0);
      tick();
      check("keep_bus1",   bus_a,    32'hCCCC);
      check("keep_k0_1",   bus_k,    32'h0);
      tick();
      check("keep_bus2",   bus_a,    32'hCCCC);
      check("keep_src",    src_a,    32'h2);
      check("keep_err",    err_a,    32'h0);

      // contention priority
      drive(4'b1010, 1'b0);
      check("pri_bus",     bus_a,    32'hBBBB);
      check("pri_cont",    cont_a,   32'h1);
      tick();
      check("pri_err",     err_a,    32'h1);
      check("pri_cnt",     cnt_a,    32'h1);
      check("pri_src",     src_a,    32'h1);
      drive(4'b0000, 1'b0);
      check("pri_keep",    bus_a,    32'hBBBB);
      tick();
      check("pri_hold_cnt", cnt_a,   32'h1);

      // clear only
      drive(4'b0000, 1'b1);
      tick();
      check("clr_cnt",     cnt_a,    32'h0);
      check("clr_err",     err_a,    32'h0);
      check("clr_cnt_c2",  cnt_c,    32'h0);

      // saturation on the 2-bit counter
      drive(4'b0011, 1'b0);
      check("sat_bus",     bus_a,    32'hAAAA);
      check("sat_cont",    cont_c,   32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("sat_cnt_c2_%0d", i), cnt_c, {30'h0, sat_exp[i]});
         check($sformatf("sat_err_c2_%0d", i), err_c, 32'h1);
      end
      check("cnt8_after5", cnt_a,    32'h5);
      check("sat_src",     src_a,    32'h0);

      // clear colliding with a new event
      drive(4'b0110, 1'b1);
      check("cev_bus",     bus_a,    32'hBBBB);
      tick();
      check("cev_cnt",     cnt_a,    32'h1);
      check("cev_err",     err_a,    32'h1);
      check("cev_cnt_c2",  cnt_c,    32'h1);
      check("cev_src",     src_a,    32'h1);

      // reset mid-drive
      drive(4'b0001, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rmd_src",     src_a,    32'h0);
      check("rmd_err",     err_a,    32'h0);
      check("rmd_cnt",     cnt_a,    32'h0);
      check("rmd_bus",     bus_a,    32'hAAAA);
      drive(4'b0000, 1'b0);
      check("rmd_release", bus_a,    32'h0);
      tick();
      check("rmd_idle",    bus_a,    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lc3_bus_keeper.md
# lc3_bus_keeper

Parametrised successor to the 16-bit tristate buffer. It merges N gated sources onto the single LC-3 datapath bus (GatePC, GateMDR, GateALU, GateMARMUX, …) as a one-hot mux, with no internal tristates. It adds three behaviours the plain buffer lacks:
- a bus keeper that holds the last driven value while no gate is active;
- deterministic priority resolution when gates collide;
- sticky and counted contention diagnostics for debug.

## Interface
Parameters:
- WIDTH, 16, bus width in bits (≥1)
- SOURCES, 4, number of gated sources (2..16)
- CNT_W, 8, width of the contention counter (≥1)
- KEEP, 1, idle policy: 1 = hold last driven value; 0 = drive all-zero when idle

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- gate  in  SOURCES  per-source drive enable; bit i enables source i
- data_in  in  SOURCES*WIDTH  packed source data; source i = data_in[i*WIDTH +: WIDTH]
- clear_err  in  1  synchronous clear of err_sticky and contention_count
- bus  out  WIDTH  resolved bus value
- driven  out  1  combinational, = |gate
- contention  out  1  combinational, high when more than one gate bit is set
- last_src  out  clog2(SOURCES)  registered index of the most recent winning source
- err_sticky  out  1  registered; set on any contention cycle
- contention_count  out  CNT_W  registered saturating count of contention cycles

## Operation
Winner selection:
- Winner = lowest index i with gate[i]=1.
- The same rule applies under contention. Output is deterministic and never an OR or X of sources.

bus (combinational):
- driven=1: bus = winner's data.
- driven=0, KEEP=1: bus = held register.
- driven=0, KEEP=0: bus = 0.

Held register (WIDTH bits):
- Loads the winner's data on every edge where driven=1.
- Otherwise retains its value.
- Updates regardless of KEEP; with KEEP=0 it is simply unobservable on bus.

last_src:
- Loads the winner index on every edge where driven=1.
- Otherwise retains its value.

err_sticky and contention_count, on each edge, in priority order:
- reset: both cleared.
- clear_err and contention both high: err_sticky=1, contention_count=1. The new event wins over the clear.
- clear_err only: err_sticky=0, contention_count=0.
- contention only: err_sticky=1, contention_count increments, saturating at 2^CNT_W−1 with no wrap.
- Otherwise: both hold.

Reset values:
- held register = 0, so bus = 0 when idle after reset.
- last_src = 0, err_sticky = 0, contention_count = 0.
- driven and contention are combinational and follow gate.

Reset mid-drive:
- Reset has priority over the load: held register = 0 and last_src = 0 after the edge, even if gate is active.
- bus still shows the combinational winner while gate stays active.

## Timing
- gate/data_in → bus, driven, contention: combinational, zero-cycle latency. This matches LC-3 single-cycle microsequencing, where the bus is sampled by the MAR/MDR/IR/REG loads on the same edge.
- Keeper value visible on bus from the first idle cycle after the last driven edge (1-cycle hold latency).
- last_src, err_sticky, contention_count: valid the cycle after the triggering edge.
- Combinational contention is visible in the same cycle as the collision.
- No handshake. Sources must keep gate and data stable across the sampling edge.
- Glitch-free selection is not guaranteed. Consumers sample only at clk edges.

## Test plan
1. **Reset:** assert reset 2 cycles with gate=0 → bus=0x0000, last_src=0, err_sticky=0, contention_count=0, driven=0.
2. **Single drive then keep:** SOURCES=4, data_in = {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA}.
   - gate=0b0100 for 1 cycle → bus=0xCCCC same cycle; last_src=2 next cycle.
   - Then gate=0 → bus stays 0xCCCC on every idle cycle.
   - With KEEP=0 → bus=0x0000 when idle.
3. **Contention priority:** gate=0b1010 → bus=0xBBBB, contention=1; next cycle err_sticky=1, contention_count=1, last_src=1.
4. **Saturation:** CNT_W=2, hold gate=0b0011 for 5 cycles → contention_count=1, 2, 3, 3, 3; err_sticky stays 1.
5. **Clear vs. event:**
   - clear_err=1 with gate=0 → count=0, err_sticky=0.
   - clear_err=1 with gate=0b0110 → count=1, err_sticky=1.
6. **Reset mid-drive:** gate=0b0001 (0xAAAA) with reset=1 for one edge.
   - After the edge: last_src=0, held register=0.
   - bus still = 0xAAAA while gate stays active.
   - On release of gate → bus=0x0000.
